// File: rtl/bipartite_pkg.sv
// bipartite_pkg: shared FSM state, index-width clamp and edge/mask helpers for the route scheduler
package bipartite_pkg;
   typedef enum logic [1:0] {IDLE, OPEN, FLUSH} state_t;
   localparam int MAX_EDGES = 1024;
   typedef logic [MAX_EDGES-1:0] edge_mask_t;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic int edge_idx(input int src, input int dst, input int n_out);
      return src * n_out + dst;
   endfunction
   // whole row of a source; an out-of-range source yields an empty mask
   function automatic edge_mask_t bcast_mask(input int src, input int n_in, input int n_out);
      return src < n_in ? ((edge_mask_t'(1) << n_out) - edge_mask_t'(1)) << edge_idx(src, 0, n_out) : '0;
   endfunction
endpackage

// File: rtl/bipartite_route_scheduler_counter.sv
// sat_down_counter: loadable down counter that saturates at zero
module sat_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero
);
   assign zero = count == '0;
   always_ff @(posedge clk)
      if (!rst_n) count <= '0;
      else if (load) count <= load_val;
      else if (dec && !zero) count <= count - W'(1);
endmodule

// File: rtl/bipartite_route_scheduler.sv
// bipartite_route_scheduler: opens one bipartite edge (or a source's whole row) per request for a dwell, then flushes
module bipartite_route_scheduler
   import bipartite_pkg::*;
#(
   parameter int N_IN         = 4,
   parameter int N_OUT        = 4,
   parameter int DWELL_W      = 8,
   parameter int FLUSH_CYCLES = 4,
   parameter int SRC_W        = idx_w(N_IN),
   parameter int DST_W        = idx_w(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [SRC_W-1:0]       req_src,
   input  logic [DST_W-1:0]       req_dst,
   input  logic                   req_bcast,
   input  logic [DWELL_W-1:0]     req_dwell,
   input  logic                   abort,
   output logic [N_IN*N_OUT-1:0]  valve_en,
   output logic                   busy,
   output logic                   done_valid,
   output logic [SRC_W-1:0]       done_src,
   output logic [DST_W-1:0]       done_dst,
   output logic                   done_aborted,
   output logic                   err
);
   localparam int E  = N_IN * N_OUT;
   localparam int FW = idx_w(FLUSH_CYCLES + 1);
   state_t             state, state_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [DST_W-1:0]   dst_q, dst_d;
   logic               bcast_q, bcast_d, aborted_q;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [FW-1:0]      flush_cnt;
   logic               dwell_zero, flush_zero;
   logic               accept, in_range, take, abort_hit, last_open, last_flush, done_d;
   logic [E-1:0]       valve_d;

   assign req_ready  = state == IDLE && rst_n;
   assign accept     = req_valid && req_ready;
   assign in_range   = int'(req_src) < N_IN && (req_bcast || int'(req_dst) < N_OUT);
   assign take       = accept && in_range;
   assign abort_hit  = state == OPEN && abort;
   assign last_open  = state == OPEN && (abort || dwell_zero || dwell_cnt == DWELL_W'(1));
   assign last_flush = state == FLUSH && (flush_zero || flush_cnt == FW'(1));

   sat_down_counter #(.W(DWELL_W)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (take),
      .dec      (state == OPEN),
      .load_val (req_dwell == '0 ? DWELL_W'(1) : req_dwell),
      .count    (dwell_cnt),
      .zero     (dwell_zero)
   );

   sat_down_counter #(.W(FW)) u_flush (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (last_open),
      .dec      (state == FLUSH),
      .load_val (FW'(FLUSH_CYCLES)),
      .count    (flush_cnt),
      .zero     (flush_zero)
   );

   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_d;

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    state_d = take ? OPEN : IDLE;
         OPEN:    state_d = !last_open ? OPEN : FLUSH_CYCLES > 0 ? FLUSH : IDLE;
         FLUSH:   state_d = last_flush ? IDLE : FLUSH;
         default: state_d = IDLE;
      endcase
   end

   // valves follow the next state so they switch on the edge after accept with no input-to-output path
   always_comb begin
      src_d   = take ? req_src : src_q;
      dst_d   = take ? (req_bcast ? '0 : req_dst) : dst_q;
      bcast_d = take ? req_bcast : bcast_q;
      done_d  = last_flush || (last_open && FLUSH_CYCLES == 0);
      valve_d = state_d != OPEN ? '0
              : bcast_d ? E'(bcast_mask(int'(src_d), N_IN, N_OUT))
              : E'(1) << edge_idx(int'(src_d), int'(dst_d), N_OUT);
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         src_q        <= '0;
         dst_q        <= '0;
         bcast_q      <= 1'b0;
         aborted_q    <= 1'b0;
         valve_en     <= '0;
         busy         <= 1'b0;
         done_valid   <= 1'b0;
         done_src     <= '0;
         done_dst     <= '0;
         done_aborted <= 1'b0;
         err          <= 1'b0;
      end else begin
         src_q      <= src_d;
         dst_q      <= dst_d;
         bcast_q    <= bcast_d;
         aborted_q  <= take ? 1'b0 : aborted_q || abort_hit;
         valve_en   <= valve_d;
         busy       <= state_d != IDLE;
         done_valid <= done_d;
         err        <= accept && !in_range;
         if (done_d) begin
            done_src     <= src_q;
            done_dst     <= dst_q;
            done_aborted <= aborted_q || abort_hit;
         end
      end
endmodule

// File: tb/tb_bipartite_route_scheduler.sv
// tb_bipartite_route_scheduler: interval-based reference model plus directed route, abort, reset and range-error vectors
module tb_bipartite_route_scheduler;
   localparam int FL = 4;
   logic        clk = 1'b0;
   logic        rst_n, req_valid, req_bcast, abort;
   logic [1:0]  req_src, req_dst;
   logic [7:0]  req_dwell;
   logic        req_ready, busy, done_valid, done_aborted, err;
   logic [1:0]  done_src, done_dst;
   logic [15:0] valve_en;
   logic        v3, b3, ready3, busy3, done3, dab3, err3;
   logic [1:0]  s3, d3, dsrc3, ddst3;
   logic [7:0]  w3;
   logic [15:0] valve3;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   bipartite_route_scheduler dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_src(req_src), .req_dst(req_dst), .req_bcast(req_bcast), .req_dwell(req_dwell),
      .abort(abort), .valve_en(valve_en), .busy(busy), .done_valid(done_valid),
      .done_src(done_src), .done_dst(done_dst), .done_aborted(done_aborted), .err(err)
   );

   bipartite_route_scheduler #(.N_IN(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3),
      .req_src(s3), .req_dst(d3), .req_bcast(b3), .req_dwell(w3),
      .abort(1'b0), .valve_en(valve3), .busy(busy3), .done_valid(done3),
      .done_src(dsrc3), .done_dst(ddst3), .done_aborted(dab3), .err(err3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: each route is a set of absolute cycle windows (open, flush end, done cycle)
   int cyc = 0, o_lo = 0, o_hi = -1, f_hi = -1, d_at = -1, eff = 0;
   int m_src = 0, m_dst = 0, e_dsrc = 0, e_ddst = 0;
   bit m_ab = 0, e_busy = 0, e_done = 0, e_dab = 0;
   logic [15:0] m_mask = '0, e_valve = '0;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         o_lo = 0;
         o_hi = -1;
         f_hi = -1;
         d_at = -1;
      end else begin
         if (abort && cyc - 1 >= o_lo && cyc - 1 <= o_hi) begin
            o_hi = cyc - 1;
            f_hi = o_hi + FL;
            d_at = f_hi + 1;
            m_ab = 1;
         end
         if (req_valid && !e_busy) begin
            eff    = req_dwell == '0 ? 1 : int'(req_dwell);
            o_lo   = cyc;
            o_hi   = cyc + eff - 1;
            f_hi   = o_hi + FL;
            d_at   = f_hi + 1;
            m_mask = 16'(req_bcast ? 32'hF << (4 * int'(req_src)) : 32'h1 << (4 * int'(req_src) + int'(req_dst)));
            m_src  = int'(req_src);
            m_dst  = req_bcast ? 0 : int'(req_dst);
            m_ab   = 0;
         end
      end
      e_valve = (cyc >= o_lo && cyc <= o_hi) ? m_mask : 16'h0;
      e_busy  = cyc >= o_lo && cyc <= f_hi;
      e_done  = cyc == d_at;
      if (e_done) begin
         e_dsrc = m_src;
         e_ddst = m_dst;
         e_dab  = m_ab;
      end
   end

   always @(negedge clk)
      if (cyc > 0) begin
         chk("valve_en", 32'(valve_en), 32'(e_valve));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done_valid", 32'(done_valid), 32'(e_done));
         chk("req_ready", 32'(req_ready), 32'(rst_n && !e_busy));
         chk("err", 32'(err), 32'h0);
         if (e_done) begin
            chk("done_src", 32'(done_src), 32'(e_dsrc));
            chk("done_dst", 32'(done_dst), 32'(e_ddst));
            chk("done_aborted", 32'(done_aborted), 32'(e_dab));
         end
      end

   logic [15:0] vh[300];
   bit dh[300], ah[300], rh[300];
   int sh[300], th[300];

   function automatic int n_eq(input int n, input logic [15:0] m);
      int c = 0;
      for (int k = 0; k < n; k++) if (vh[k] === m) c++;
      return c;
   endfunction

   function automatic int first_done(input int n);
      for (int k = 0; k < n; k++) if (dh[k]) return k;
      return -1;
   endfunction

   function automatic int n_done(input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (dh[k]) c++;
      return c;
   endfunction

   function automatic logic [15:0] any_bits(input int n, input logic [15:0] m);
      logic [15:0] acc = '0;
      for (int k = 0; k < n; k++) acc |= vh[k] & m;
      return acc;
   endfunction

   task automatic send(input int s, input int d, input int b, input int w);
      bit r = 0;
      req_valid = 1'b1;
      req_src   = 2'(s);
      req_dst   = 2'(d);
      req_bcast = b[0];
      req_dwell = 8'(w);
      for (int k = 0; k < 500 && !r; k++) begin
         @(negedge clk);
         r = req_ready;
         @(posedge clk);
         #1;
      end
      if (!r) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: req_ready never rose for src %0d", s);
      end
      req_valid = 1'b0;
      req_src   = 2'($urandom);
      req_dst   = 2'($urandom);
      req_bcast = 1'($urandom);
      req_dwell = 8'($urandom);
   endtask

   task automatic capture(input int n, input int a1, input int a2, input int a3, input int rst_at);
      bit drop;
      for (int k = 0; k < n; k++) begin
         abort = k == a1 || k == a2 || k == a3;
         rst_n = k != rst_at;
         @(negedge clk);
         vh[k] = valve_en;
         dh[k] = done_valid;
         sh[k] = int'(done_src);
         th[k] = int'(done_dst);
         ah[k] = done_aborted;
         rh[k] = req_ready;
         drop  = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (drop) req_valid = 1'b0;
      end
      abort = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_bcast = 1'b0; req_dwell = '0; abort = 1'b0;
      v3 = 1'b0; s3 = '0; d3 = '0; b3 = 1'b0; w3 = '0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_valve", 32'(valve_en), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done_valid), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1, 2, 0, 3);
      capture(10, -1, -1, -1, -1);
      chk("t1_open_cycles", n_eq(10, 16'h0040), 3);
      chk("t1_first_open", 32'(vh[0]), 32'h0040);
      chk("t1_flush_closed", 32'(vh[3] | vh[6]), 32'h0);
      chk("t1_done_idx", first_done(10), 7);
      chk("t1_done_src", sh[7], 1);
      chk("t1_done_dst", th[7], 2);
      chk("t1_done_aborted", 32'(ah[7]), 32'h0);
      send(3, 3, 1, 2);
      capture(8, -1, -1, -1, -1);
      chk("bc_open_cycles", n_eq(8, 16'hF000), 2);
      chk("bc_other_rows", 32'(any_bits(8, 16'h0FFF)), 32'h0);
      chk("bc_done_idx", first_done(8), 6);
      chk("bc_done_dst", th[6], 0);
      send(2, 3, 0, 0);
      capture(7, -1, -1, -1, -1);
      chk("dw0_open_cycles", n_eq(7, 16'h0800), 1);
      chk("dw0_done_idx", first_done(7), 5);
      send(0, 1, 0, 255);
      capture(262, -1, -1, -1, -1);
      chk("dw255_open_cycles", n_eq(262, 16'h0002), 255);
      chk("dw255_done_idx", first_done(262), 259);
      send(0, 0, 0, 10);
      capture(12, 3, 5, 10, -1);
      chk("ab_open_cycles", n_eq(12, 16'h0001), 4);
      chk("ab_done_idx", first_done(12), 8);
      chk("ab_done_count", n_done(12), 1);
      chk("ab_done_aborted", 32'(ah[8]), 32'h1);
      send(1, 1, 0, 2);
      req_valid = 1'b1; req_src = 2'd2; req_dst = 2'd0; req_bcast = 1'b0; req_dwell = 8'd1;
      capture(14, -1, -1, -1, -1);
      chk("b2b_a_open", n_eq(14, 16'h0020), 2);
      chk("b2b_a_done", 32'(dh[6]), 32'h1);
      chk("b2b_a_done_src", sh[6], 1);
      chk("b2b_ready_in_done", 32'(rh[6]), 32'h1);
      chk("b2b_b_open", 32'(vh[7]), 32'h0100);
      chk("b2b_b_done_src", sh[12], 2);
      send(3, 3, 0, 5);
      capture(5, -1, -1, -1, 1);
      chk("rst_mid_open", 32'(vh[1]), 32'h8000);
      chk("rst_closed", 32'(vh[2]), 32'h0);
      chk("rst_no_done", n_done(5), 0);
      chk("rst_ready_low", 32'(rh[1]), 32'h0);
      chk("rst_ready_after", 32'(rh[2]), 32'h1);
      v3 = 1'b1; s3 = 2'd3; d3 = 2'd0; b3 = 1'b0; w3 = 8'd2;
      @(posedge clk);
      #1 v3 = 1'b0;
      @(negedge clk);
      chk("n3_err_pulse", 32'(err3), 32'h1);
      chk("n3_err_valve", 32'(valve3), 32'h0);
      chk("n3_err_busy", 32'(busy3), 32'h0);
      chk("n3_err_ready", 32'(ready3), 32'h1);
      @(negedge clk);
      chk("n3_err_once", 32'(err3), 32'h0);
      @(posedge clk);
      #1;
      v3 = 1'b1; s3 = 2'd2; d3 = 2'd1; w3 = 8'd1;
      @(posedge clk);
      #1 v3 = 1'b0;
      @(negedge clk);
      chk("n3_ok_valve", 32'(valve3), 32'h0200);
      chk("n3_ok_busy", 32'(busy3), 32'h1);
      repeat (5) @(negedge clk);
      chk("n3_ok_done", 32'(done3), 32'h1);
      chk("n3_ok_done_src", 32'(dsrc3), 32'h2);
      chk("n3_ok_done_dst", 32'(ddst3), 32'h1);
      chk("n3_ok_not_aborted", 32'(dab3), 32'h0);
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
